// File: rtl/fc_layer_link.sv
`default_nettype none
// ============================================================================
// Module  : fc_layer_link
// Brief   : Buffers one full output vector from an upstream fc_layer and
//           replays it into the downstream ibuf, then pulses its start.
// Revision: 1.0 - initial release
// ============================================================================
module fc_layer_link #(
  parameter int datatype_size = 4,
  parameter int vector_size   = 784,
  parameter int addr_width    = $clog2(vector_size)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_func_valid,
  input  logic [datatype_size-1:0] i_func_data,
  output logic                     o_busy,
  input  logic                     i_next_busy,
  output logic                     o_ibuf_we,
  output logic [datatype_size-1:0] o_ibuf_wr_data,
  output logic [addr_width-1:0]    o_ibuf_addr,
  output logic                     o_start,
  output logic                     o_overflow
);

  localparam logic [1:0] FILL  = 2'd0;
  localparam logic [1:0] WAIT  = 2'd1;
  localparam logic [1:0] DRAIN = 2'd2;
  localparam logic [1:0] START = 2'd3;

  localparam logic [addr_width-1:0] c_last = addr_width'(vector_size - 1);
  localparam logic [addr_width-1:0] c_one  = addr_width'(1);

  logic [1:0]               r_state;
  logic [addr_width-1:0]    r_wr_cnt;
  logic [addr_width-1:0]    r_rd_cnt;
  logic [datatype_size-1:0] r_buf [vector_size];
  logic                     r_ibuf_we;
  logic [datatype_size-1:0] r_ibuf_wr_data;
  logic [addr_width-1:0]    r_ibuf_addr;
  logic                     r_start;
  logic                     r_overflow;
  logic                     w_accept;

  assign o_busy   = (r_state != FILL);
  assign w_accept = (r_state == FILL) && i_func_valid;

  // Buffer contents are don't-care after reset, so the array carries no reset.
  always_ff @(posedge clk) begin
    if (!rst && w_accept) begin
      r_buf[r_wr_cnt] <= i_func_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state        <= FILL;
      r_wr_cnt       <= '0;
      r_rd_cnt       <= '0;
      r_ibuf_we      <= 1'b0;
      r_ibuf_wr_data <= '0;
      r_ibuf_addr    <= '0;
      r_start        <= 1'b0;
      r_overflow     <= 1'b0;
    end else begin
      r_ibuf_we <= 1'b0;
      r_start   <= 1'b0;
      if (i_func_valid && (r_state != FILL)) begin
        r_overflow <= 1'b1;
      end
      case (r_state)
        FILL: begin
          if (i_func_valid) begin
            if (r_wr_cnt == c_last) begin
              r_wr_cnt <= '0;
              r_state  <= WAIT;
            end else begin
              r_wr_cnt <= r_wr_cnt + c_one;
            end
          end
        end
        WAIT: begin
          if (!i_next_busy) begin
            r_rd_cnt <= '0;
            r_state  <= DRAIN;
          end
        end
        DRAIN: begin
          r_ibuf_we      <= 1'b1;
          r_ibuf_addr    <= r_rd_cnt;
          r_ibuf_wr_data <= r_buf[r_rd_cnt];
          if (r_rd_cnt == c_last) begin
            r_rd_cnt <= '0;
            r_state  <= START;
          end else begin
            r_rd_cnt <= r_rd_cnt + c_one;
          end
        end
        START: begin
          // First START cycle lets the last write retire; the second carries o_start.
          if (!r_start) begin
            r_start <= 1'b1;
          end else begin
            r_wr_cnt <= '0;
            r_rd_cnt <= '0;
            r_state  <= FILL;
          end
        end
        default: r_state <= FILL;
      endcase
    end
  end

  assign o_ibuf_we      = r_ibuf_we;
  assign o_ibuf_wr_data = r_ibuf_wr_data;
  assign o_ibuf_addr    = r_ibuf_addr;
  assign o_start        = r_start;
  assign o_overflow     = r_overflow;

endmodule
`default_nettype wire

// File: doc/fc_layer_link.md
FC_LAYER_LINK -- requirements
Module: fc_layer_link

Interface
REQ-001 The block SHALL have parameter datatype_size, default 4, meaning the element width in bits.
REQ-002 The block SHALL have parameter vector_size, default 784, meaning the upstream output_size, which equals the downstream input_size.
REQ-003 The block SHALL have parameter addr_width, default $clog2(vector_size), meaning the ibuf address width.
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock; all logic is on the rising edge.
REQ-005 The block SHALL have port rst, input, 1 bit: the reset, which is synchronous and active-high.
REQ-006 The block SHALL have port i_func_valid, input, 1 bit: the upstream fc_layer presents one output element this cycle.
REQ-007 The block SHALL have port i_func_data, input, datatype_size bits: the upstream o_func_data element.
REQ-008 The block SHALL have port o_busy, input-side handshake output, 1 bit, driven to upstream i_next_busy: high means upstream must not present elements.
REQ-009 The block SHALL have port i_next_busy, input, 1 bit: the downstream fc_layer o_busy.
REQ-010 The block SHALL have port o_ibuf_we, output, 1 bit: the downstream ibuf write enable.
REQ-011 The block SHALL have port o_ibuf_wr_data, output, datatype_size bits: the downstream ibuf write data.
REQ-012 The block SHALL have port o_ibuf_addr, output, addr_width bits: the downstream ibuf address.
REQ-013 The block SHALL have port o_start, output, 1 bit: a one-cycle pulse to downstream i_start.
REQ-014 The block SHALL have port o_overflow, output, 1 bit: a sticky flag set when data arrives while o_busy is high.

Function
REQ-015 The block SHALL hold an internal vector_size x datatype_size buffer, with write counter wr_cnt and read counter rd_cnt, each addr_width bits.
REQ-016 The state machine SHALL have states FILL, WAIT, DRAIN and START, and SHALL leave reset in FILL.
REQ-017 In FILL, o_busy SHALL be 0, and each cycle with i_func_valid=1 SHALL write i_func_data to buf[wr_cnt] and then increment wr_cnt.
REQ-018 In FILL, accepting an element with wr_cnt=vector_size-1 SHALL clear wr_cnt to 0 with no overflow past vector_size-1, and SHALL move to WAIT on the next cycle.
REQ-019 In WAIT, START and DRAIN, o_busy SHALL be 1.
REQ-020 In WAIT, o_ibuf_we SHALL be 0, and the block SHALL stay in WAIT while i_next_busy=1.
REQ-021 In WAIT, the first cycle sampling i_next_busy=0 SHALL move to DRAIN with rd_cnt=0.
REQ-022 In DRAIN, each cycle SHALL read buf[rd_cnt] and increment rd_cnt.
REQ-023 All o_ibuf_* outputs SHALL be registered, so the write for rd_cnt=k appears one cycle after the read.
REQ-024 Over DRAIN, o_ibuf_we SHALL be high for exactly vector_size consecutive cycles, with o_ibuf_addr running 0,1,...,vector_size-1 and o_ibuf_wr_data=buf[addr].
REQ-025 After the read at rd_cnt=vector_size-1, the block SHALL go to START.
REQ-026 o_start SHALL be 1 for exactly one cycle, in the cycle immediately after the last o_ibuf_we cycle.
REQ-027 After the o_start cycle, the block SHALL return to FILL with wr_cnt=0 and rd_cnt=0.
REQ-028 The block SHALL sample i_next_busy only in WAIT, and SHALL ignore it during DRAIN and START.
REQ-029 If i_func_valid=1 while o_busy=1, the element SHALL be dropped, the buffer SHALL be unchanged, and o_overflow SHALL be set to 1 and held until rst.
REQ-030 Latency SHALL be as follows: with i_next_busy=0 and the last element accepted in cycle t, the first o_ibuf_we SHALL be in cycle t+3 and o_start SHALL be in cycle t+3+vector_size.
REQ-031 A one-cycle gap in i_func_valid during FILL SHALL only stall the fill and SHALL NOT change wr_cnt.

Reset
REQ-032 A rst sampled high SHALL force FILL, wr_cnt=0, rd_cnt=0, o_busy=0, o_ibuf_we=0, o_ibuf_addr=0, o_ibuf_wr_data=0, o_start=0 and o_overflow=0 at the next edge.
REQ-033 A rst in any state, including mid-DRAIN, SHALL abort the transfer with no o_start, and the buffer contents SHALL be don't-care.
REQ-034 rst SHALL take priority over every simultaneous event.

Verification (vector_size=4, datatype_size=4)
REQ-035 Scenario: feed 3,7,1,F on 4 consecutive valid cycles with i_next_busy=0 -> o_ibuf_we on addr 0..3 with data 3,7,1,F starting 3 cycles after the last element, then a single o_start pulse.
REQ-036 Scenario: fill the buffer with i_next_busy=1 held for 10 cycles -> o_busy=1 throughout, o_ibuf_we=0, and DRAIN begins 2 cycles after i_next_busy falls.
REQ-037 Scenario: pulse i_func_valid with data 5 while in WAIT -> o_overflow=1, and the drained data is unchanged.
REQ-038 Scenario: feed valid elements with gaps (pattern 1,0,1,1,0,1) -> exactly 4 elements are captured in order.
REQ-039 Scenario: assert rst on the 2nd DRAIN write -> all outputs are 0 the next cycle, no o_start, and the block accepts a fresh vector.
REQ-040 Scenario: send two back-to-back vectors -> the second FILL starts the cycle after o_start, and both o_start pulses are separated by at least vector_size+3 cycles.
